// File: rtl/uart_slot_master.sv
// MMIO initiator for the UART slot: programs the baud divisor, then moves bytes
// between a TX/RX valid/ready byte-stream pair and the UART FIFOs by status polling.
//
// Handshakes: a byte moves on tx_* when tx_valid && tx_ready at a rising edge, and on
// rx_* when rx_valid && rx_ready at a rising edge; valid never waits on ready, and
// valid/data stay stable until the transfer happens.
module uart_slot_master #(
   parameter int DVSR_W   = 11,
   parameter bit RX_FIRST = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DVSR_W-1:0] dvsr_in,
   input  logic              cfg_req,
   input  logic              tx_valid,
   input  logic [7:0]        tx_byte,
   output logic              tx_ready,
   output logic              rx_valid,
   output logic [7:0]        rx_byte,
   input  logic              rx_ready,
   output logic              cs,
   output logic              read,
   output logic              write,
   output logic [4:0]        addr,
   output logic [31:0]       wr_data,
   input  logic [31:0]       rd_data
);

   typedef enum logic [2:0] {
      RST_IDLE,
      CFG,
      POLL,
      TX_WR,
      RX_POP
   } state_t;

   state_t            state;
   state_t            next_state;
   logic              cfg_pend;
   logic              last_rx;
   logic [DVSR_W-1:0] dvsr_q;
   logic [7:0]        tx_q;
   logic              tx_elig;
   logic              rx_elig;
   logic              unused_rd_hi;

   assign unused_rd_hi = ^rd_data[31:10];

   always_comb begin
      tx_elig    = tx_valid && !rd_data[9];
      rx_elig    = !rd_data[8] && !rx_valid;
      next_state = state;
      case (state)
         RST_IDLE: next_state = CFG;
         CFG:      next_state = POLL;
         POLL: begin
            if (cfg_pend)
               next_state = CFG;
            else if (tx_elig && rx_elig)
               next_state = last_rx ? TX_WR : RX_POP;
            else if (tx_elig)
               next_state = TX_WR;
            else if (rx_elig)
               next_state = RX_POP;
            else
               next_state = POLL;
         end
         TX_WR:    next_state = POLL;
         RX_POP:   next_state = POLL;
         default:  next_state = RST_IDLE;
      endcase
   end

   // dvsr_in and tx_byte are captured on entry so the slot outputs come from registers only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= RST_IDLE;
         cfg_pend <= 1'b0;
         last_rx  <= ~RX_FIRST;
         dvsr_q   <= '0;
         tx_q     <= '0;
         rx_valid <= 1'b0;
         rx_byte  <= '0;
      end else begin
         state    <= next_state;
         cfg_pend <= cfg_req || (cfg_pend && state != CFG);
         if (next_state == CFG)
            dvsr_q <= dvsr_in;
         if (state == POLL && next_state == TX_WR) begin
            tx_q    <= tx_byte;
            last_rx <= 1'b0;
         end
         if (state == POLL && next_state == RX_POP) begin
            rx_byte <= rd_data[7:0];
            last_rx <= 1'b1;
         end
         if (state == RX_POP)
            rx_valid <= 1'b1;
         else if (rx_valid && rx_ready)
            rx_valid <= 1'b0;
      end
   end

   always_comb begin
      cs       = 1'b0;
      read     = 1'b0;
      write    = 1'b0;
      addr     = 5'd0;
      wr_data  = 32'h0;
      tx_ready = 1'b0;
      case (state)
         CFG: begin
            cs      = 1'b1;
            write   = 1'b1;
            addr    = 5'd1;
            wr_data = {{(32-DVSR_W){1'b0}}, dvsr_q};
         end
         POLL: begin
            cs   = 1'b1;
            read = 1'b1;
         end
         TX_WR: begin
            cs       = 1'b1;
            write    = 1'b1;
            addr     = 5'd2;
            wr_data  = {24'h0, tx_q};
            tx_ready = 1'b1;
         end
         RX_POP: begin
            cs    = 1'b1;
            write = 1'b1;
            addr  = 5'd3;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_uart_slot_master.sv
// Bench for uart_slot_master: a slot model answers status reads from a small RX FIFO
// model, and scoreboards track bytes pushed to the UART and bytes delivered on rx_*.
module tb_uart_slot_master;

   localparam int K_IDLE = 0;
   localparam int K_CFG  = 1;
   localparam int K_POLL = 2;
   localparam int K_TX   = 3;
   localparam int K_RX   = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] dvsr_in;
   logic        cfg_req;
   logic        tx_valid;
   logic [7:0]  tx_byte;
   logic        tx_ready;
   logic        rx_valid;
   logic [7:0]  rx_byte;
   logic        rx_ready;
   logic        cs;
   logic        read;
   logic        write;
   logic [4:0]  addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;

   logic        tx_full_m;
   logic        rx_empty_m;
   logic [7:0]  rx_head_m;
   logic [10:0] exp_dvsr;

   logic [7:0]  tx_src_q[$];
   logic [7:0]  tx_exp_q[$];
   logic [7:0]  rx_fifo[$];
   logic [7:0]  rx_exp_q[$];

   int total = 0;
   int bad   = 0;

   uart_slot_master #(.DVSR_W(11), .RX_FIRST(1'b0)) dut (
      .clk      (clk),
      .reset    (reset),
      .dvsr_in  (dvsr_in),
      .cfg_req  (cfg_req),
      .tx_valid (tx_valid),
      .tx_byte  (tx_byte),
      .tx_ready (tx_ready),
      .rx_valid (rx_valid),
      .rx_byte  (rx_byte),
      .rx_ready (rx_ready),
      .cs       (cs),
      .read     (read),
      .write    (write),
      .addr     (addr),
      .wr_data  (wr_data),
      .rd_data  (rd_data)
   );

   always #5 clk = ~clk;

   assign rd_data = {22'h0, tx_full_m, rx_empty_m, rx_head_m};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] bus_exp(input int k);
      // packed as {cs, read, write, addr[4:0], tx_ready}
      case (k)
         K_CFG:   return {23'h0, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0};
         K_POLL:  return {23'h0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0};
         K_TX:    return {23'h0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1};
         K_RX:    return {23'h0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0};
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] bus_now();
      return {23'h0, cs, read, write, addr, tx_ready};
   endfunction

   task automatic slot_update();
      rx_empty_m = (rx_fifo.size() == 0);
      rx_head_m  = (rx_fifo.size() == 0) ? 8'h00 : rx_fifo[0];
   endtask

   task automatic tx_refresh();
      tx_valid = (tx_src_q.size() != 0);
      tx_byte  = (tx_src_q.size() != 0) ? tx_src_q[0] : 8'h00;
   endtask

   task automatic tx_push(input logic [7:0] b);
      tx_src_q.push_back(b);
      tx_exp_q.push_back(b);
      tx_refresh();
   endtask

   task automatic rx_push(input logic [7:0] b);
      rx_fifo.push_back(b);
      rx_exp_q.push_back(b);
      slot_update();
   endtask

   // One cycle: account for an rx handshake at the coming edge, then check the
   // transaction shown in the following cycle and update the source/slot models.
   task automatic tick(input int k, input string tag);
      logic [7:0] e;
      if (rx_valid && rx_ready) begin
         if (rx_exp_q.size() == 0)
            chk("rx_unexpected", 32'(rx_exp_q.size()), 32'd1);
         else begin
            e = rx_exp_q.pop_front();
            chk("rx_data", {24'h0, rx_byte}, {24'h0, e});
         end
      end
      @(negedge clk);
      chk({tag, "_bus"}, bus_now(), bus_exp(k));
      if (k == K_CFG)
         chk({tag, "_dvsr"}, wr_data, {21'h0, exp_dvsr});
      if (k == K_RX || k == K_IDLE)
         chk({tag, "_wrd"}, wr_data, 32'h0);
      if (write && addr == 5'd2) begin
         if (tx_exp_q.size() == 0)
            chk("tx_unexpected", 32'(tx_exp_q.size()), 32'd1);
         else begin
            e = tx_exp_q.pop_front();
            chk("tx_data", wr_data, {24'h0, e});
         end
      end
      if (tx_ready) begin
         if (tx_src_q.size() != 0)
            void'(tx_src_q.pop_front());
         tx_refresh();
      end
      if (write && addr == 5'd3) begin
         chk("rx_pop_nonempty", 32'(rx_fifo.size() != 0), 32'd1);
         if (rx_fifo.size() != 0)
            void'(rx_fifo.pop_front());
         slot_update();
      end
   endtask

   initial begin
      reset     = 1'b0;
      dvsr_in   = 11'd325;
      exp_dvsr  = 11'd325;
      cfg_req   = 1'b0;
      rx_ready  = 1'b0;
      tx_full_m = 1'b0;
      tx_refresh();
      slot_update();

      // reset state and release
      tick(K_IDLE, "rst0");
      tick(K_IDLE, "rst1");
      chk("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
      chk("rst_rx_byte", {24'h0, rx_byte}, 32'h0);
      reset = 1'b1;
      tick(K_CFG, "boot_cfg");
      for (int i = 0; i < 3; i++) tick(K_POLL, "boot_poll");

      // TX, then TX held off by tx_full
      tx_push(8'h5A);
      tick(K_TX, "tx1");
      tick(K_POLL, "tx1_poll");
      tx_full_m = 1'b1;
      tx_push(8'hA5);
      for (int i = 0; i < 8; i++) tick(K_POLL, "tx_full");
      tx_full_m = 1'b0;
      tick(K_TX, "tx2");
      tick(K_POLL, "tx2_poll");

      // RX into a held buffer, then release
      rx_push(8'hC3);
      rx_push(8'h3C);
      tick(K_RX, "rx1");
      tick(K_POLL, "rx1_poll");
      chk("rx1_valid", {31'h0, rx_valid}, 32'h1);
      chk("rx1_byte", {24'h0, rx_byte}, 32'hC3);
      for (int i = 0; i < 4; i++) tick(K_POLL, "rx_hold");
      rx_ready = 1'b1;
      tick(K_POLL, "rx_free");
      chk("rx_cleared", {31'h0, rx_valid}, 32'h0);
      tick(K_RX, "rx2");
      tick(K_POLL, "rx2_poll");
      tick(K_POLL, "rx2_hs");
      tick(K_POLL, "rx_idle");
      chk("rx_idle_valid", {31'h0, rx_valid}, 32'h0);

      // both sides eligible: strict alternation
      for (int i = 0; i < 4; i++) begin
         tx_push(8'($urandom_range(0, 255)));
         rx_push(8'($urandom_range(0, 255)));
      end
      for (int i = 0; i < 4; i++) begin
         tick(K_TX, "alt_tx");
         tick(K_POLL, "alt_p1");
         tick(K_RX, "alt_rx");
         tick(K_POLL, "alt_p2");
      end
      tick(K_POLL, "alt_end");

      // divisor rewrite requested during TX_WR
      dvsr_in  = 11'd27;
      exp_dvsr = 11'd27;
      tx_push(8'h11);
      tx_push(8'h22);
      tick(K_TX, "cfg_tx");
      cfg_req = 1'b1;
      tick(K_POLL, "cfg_poll");
      cfg_req = 1'b0;
      tick(K_CFG, "cfg_re");
      tick(K_POLL, "cfg_poll2");
      tick(K_TX, "cfg_resume");
      tick(K_POLL, "cfg_poll3");

      // request arriving while CFG clears the flag forces one more CFG
      cfg_req = 1'b1;
      tick(K_POLL, "cfg2_poll");
      cfg_req = 1'b0;
      tick(K_CFG, "cfg2_a");
      cfg_req = 1'b1;
      tick(K_POLL, "cfg2_poll2");
      cfg_req = 1'b0;
      tick(K_CFG, "cfg2_b");
      tick(K_POLL, "cfg2_poll3");
      tick(K_POLL, "cfg2_poll4");

      // reset mid-TX_WR with a full rx buffer
      rx_ready = 1'b0;
      rx_push(8'h77);
      tx_push(8'h33);
      tick(K_RX, "mr_rx");
      tick(K_POLL, "mr_poll");
      chk("mr_rx_valid", {31'h0, rx_valid}, 32'h1);
      tick(K_TX, "mr_tx");
      dvsr_in  = 11'd325;
      exp_dvsr = 11'd325;
      reset    = 1'b0;
      #1;
      chk("mr_bus", bus_now(), 32'h0);
      chk("mr_wrd", wr_data, 32'h0);
      chk("mr_rx_valid0", {31'h0, rx_valid}, 32'h0);
      chk("mr_rx_byte0", {24'h0, rx_byte}, 32'h0);
      chk("mr_rx_discard", 32'(rx_exp_q.size()), 32'd1);
      if (rx_exp_q.size() != 0)
         void'(rx_exp_q.pop_front());
      @(negedge clk);
      chk("mr_hold_bus", bus_now(), 32'h0);
      reset = 1'b1;
      tick(K_CFG, "mr_cfg");
      tick(K_POLL, "mr_p1");
      tick(K_POLL, "mr_p2");

      // first contention after reset goes to TX (RX_FIRST=0)
      rx_ready = 1'b1;
      tx_push(8'h44);
      rx_push(8'h55);
      tick(K_TX, "first_tx");
      tick(K_POLL, "first_p1");
      tick(K_RX, "first_rx");
      tick(K_POLL, "first_p2");
      tick(K_POLL, "first_p3");

      chk("tx_exp_drained", 32'(tx_exp_q.size()), 32'd0);
      chk("rx_exp_drained", 32'(rx_exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
